// File: rtl/lsu_mem_master_pkg.sv
// Shared definitions for the load/store memory master: size and write-mode
// codes, FSM states and the access legality check.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] WM_NONE = 2'd0;
  localparam logic [1:0] WM_BYTE = 2'd1;
  localparam logic [1:0] WM_HALF = 2'd2;
  localparam logic [1:0] WM_WORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Legal = known size and naturally aligned; the reserved size is never legal.
  function automatic logic access_ok(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: access_ok = 1'b1;
      SZ_HALF: access_ok = ~addr_lo[0];
      SZ_WORD: access_ok = (addr_lo == 2'b00);
      default: access_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] size_to_wmode(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_to_wmode = WM_BYTE;
      SZ_HALF: size_to_wmode = WM_HALF;
      SZ_WORD: size_to_wmode = WM_WORD;
      default: size_to_wmode = WM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response and RAM-port bundle of the load/store memory master.
interface lsu_mem_master_if #(
  parameter int W  = 32,
  parameter int AW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata;
  logic          resp_valid;
  logic [W-1:0]  resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mem_oe;
  logic [1:0]    mem_w_mode;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_oe, mem_w_mode
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_oe, mem_w_mode
  );
endinterface

// File: rtl/lsu_mem_master_load_ext.sv
// Little-endian load field extraction with sign or zero extension.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] rdata,
  input  logic [1:0]   size,
  input  logic         is_unsigned,
  output logic [W-1:0] data
);

  always_comb begin
    data = rdata;
    case (size)
      SZ_BYTE: data = {{(W-8){~is_unsigned & rdata[7]}}, rdata[7:0]};
      SZ_HALF: data = {{(W-16){~is_unsigned & rdata[15]}}, rdata[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request at a time, IDLE -> ACCESS -> RESP,
// with illegal requests short-circuiting straight to RESP.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int W  = 32,
  parameter int L  = 64,
  parameter int AW = $clog2(L * (W / 8))
) (
  input logic clk,
  input logic rst,
  lsu_mem_master_if.master bus
);

  state_t        state;
  logic          r_we;
  logic          r_uns;
  logic          r_err;
  logic [1:0]    r_size;
  logic [AW-1:0] r_addr;
  logic [W-1:0]  r_wdata;
  logic [W-1:0]  r_rdata;
  logic [W-1:0]  ext_data;

  lsu_load_ext #(.W(W)) u_load_ext (
    .rdata       (bus.mem_rdata),
    .size        (r_size),
    .is_unsigned (r_uns),
    .data        (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      r_we           <= 1'b0;
      r_uns          <= 1'b0;
      r_err          <= 1'b0;
      r_size         <= SZ_BYTE;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rdata        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      // Response outputs are registered from the RESP state, so they appear one cycle after it.
      bus.resp_valid <= (state == RESP);
      bus.resp_err   <= (state == RESP) & r_err;
      bus.resp_rdata <= (state == RESP) ? r_rdata : '0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_uns   <= bus.req_unsigned;
            r_size  <= bus.req_size;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_rdata <= '0;
            r_err   <= ~access_ok(bus.req_size, bus.req_addr[1:0]);
            state   <= access_ok(bus.req_size, bus.req_addr[1:0]) ? ACCESS : RESP;
          end
        end
        ACCESS: begin
          r_rdata <= r_we ? '0 : ext_data;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE) & ~rst;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  // Strobes gated by rst so a reset landing in ACCESS cannot commit a write.
  assign bus.mem_oe     = (state == ACCESS) & ~r_we & ~rst;
  assign bus.mem_w_mode = ((state == ACCESS) & r_we & ~rst) ? size_to_wmode(r_size) : WM_NONE;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural byte RAM and a response scoreboard.
module tb_lsu_mem_master;

  logic clk;
  logic rst;
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   writes     = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  lsu_mem_master_if #(.W(32), .AW(8)) bus ();

  lsu_mem_master #(.W(32), .L(64), .AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:255];
  logic [7:0] ra;
  assign ra = bus.mem_addr;
  assign bus.mem_rdata = bus.mem_oe ? {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]} : 'z;

  always @(posedge clk) begin
    if (bus.mem_w_mode != 2'd0) begin
      writes <= writes + 1;
      mem[ra] <= bus.mem_wdata[7:0];
      if (bus.mem_w_mode >= 2'd2) mem[ra + 8'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_w_mode == 2'd3) begin
        mem[ra + 8'd2] <= bus.mem_wdata[23:16];
        mem[ra + 8'd3] <= bus.mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", {31'b0, bus.resp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
        check("resp_latency", cyc - e.acc, e.lat);
      end
    end else if (!rst) begin
      check("resp_quiet", bus.resp_rdata | {31'b0, bus.resp_err}, 32'd0);
    end
  end

  // Called at a negedge; returns after the following negedge. hold keeps req_valid high.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input bit push, input bit hold, output int acc);
    int n;
    exp_t e;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    acc = cyc;
    if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.acc   = acc;
      e.lat   = exp_err ? 2 : 3;
      sb.push_back(e);
    end
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  initial begin
    int a0, a1, a2, a3, wr0, n;
    for (int unsigned i = 0; i < 256; i++) mem[i] = 8'(i);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_mem_oe_wmode", {29'b0, bus.mem_oe, bus.mem_w_mode}, 32'd0);
    check("rst_mem_addr", {24'b0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);

    issue(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, 0, a0);
    issue(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0, a0);
    issue(1'b0, 2'd0, 1'b0, 8'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 1, 0, a0);
    issue(1'b0, 2'd0, 1'b1, 8'h13, 32'h0, 32'h000000DE, 1'b0, 1, 0, a0);
    issue(1'b0, 2'd1, 1'b0, 8'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 1, 0, a0);
    issue(1'b0, 2'd1, 1'b1, 8'h10, 32'h0, 32'h0000BEEF, 1'b0, 1, 0, a0);
    issue(1'b1, 2'd1, 1'b0, 8'h10, 32'h00001234, 32'h0, 1'b0, 1, 0, a0);
    issue(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'hDEAD1234, 1'b0, 1, 0, a0);
    issue(1'b1, 2'd0, 1'b0, 8'h13, 32'h00000077, 32'h0, 1'b0, 1, 0, a0);
    issue(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'h77AD1234, 1'b0, 1, 0, a0);

    repeat (4) @(negedge clk);
    wr0 = writes;
    issue(1'b0, 2'd2, 1'b0, 8'h11, 32'h0, 32'h0, 1'b1, 1, 0, a0);
    issue(1'b1, 2'd1, 1'b0, 8'h21, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, a0);
    issue(1'b1, 2'd3, 1'b0, 8'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1, a0);
    issue(1'b0, 2'd3, 1'b0, 8'h10, 32'h0, 32'h0, 1'b1, 1, 0, a1);
    check("err_throughput", a1 - a0, 32'd2);
    repeat (4) @(negedge clk);
    check("err_no_writes", writes - wr0, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'h77AD1234, 1'b0, 1, 0, a0);

    issue(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'h77AD1234, 1'b0, 1, 1, a0);
    issue(1'b0, 2'd0, 1'b1, 8'h11, 32'h0, 32'h00000012, 1'b0, 1, 1, a1);
    issue(1'b0, 2'd1, 1'b0, 8'h20, 32'h0, 32'h00002120, 1'b0, 1, 1, a2);
    issue(1'b0, 2'd0, 1'b0, 8'h83, 32'h0, 32'hFFFFFF83, 1'b0, 1, 0, a3);
    check("b2b_gap0", a1 - a0, 32'd3);
    check("b2b_gap1", a2 - a1, 32'd3);
    check("b2b_gap2", a3 - a2, 32'd3);

    repeat (4) @(negedge clk);
    wr0 = writes;
    issue(1'b1, 2'd2, 1'b0, 8'h20, 32'hCAFEF00D, 32'h0, 1'b0, 0, 0, a0);
    rst = 1'b1;
    #1;
    check("rst_access_wmode", {30'b0, bus.mem_w_mode}, 32'd0);
    check("rst_access_oe", {31'b0, bus.mem_oe}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_access_ready", {31'b0, bus.req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("rst_access_no_write", writes - wr0, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 32'h23222120, 1'b0, 1, 0, a0);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
